// File: rtl/multdiv_sequencer.sv
// Sequencer beside the X stage for the multi-cycle multiplier/divider.
// It latches the operands, strobes the unit, stalls the front end and issues one writeback.
module multdiv_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int TIMEOUT      = 40,
  parameter int RSTATUS_REG  = 30,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dx_is_mult,
  input  logic                  dx_is_div,
  input  logic [DATA_WIDTH-1:0] dx_operand_a,
  input  logic [DATA_WIDTH-1:0] dx_operand_b,
  input  logic [4:0]            dx_rd,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] md_result,
  input  logic                  md_ready,
  input  logic                  md_exception,
  output logic                  md_ctrl_mult,
  output logic                  md_ctrl_div,
  output logic [DATA_WIDTH-1:0] md_data_a,
  output logic [DATA_WIDTH-1:0] md_data_b,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [4:0]            wb_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [1:0]            fsm_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]         LAST_BUSY = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]         SAT_VAL   = CW'(TIMEOUT);
  localparam logic [4:0]            RS_REG    = 5'(RSTATUS_REG);
  localparam logic [DATA_WIDTH-1:0] MUL_CODE  = DATA_WIDTH'(MUL_EXC_CODE);
  localparam logic [DATA_WIDTH-1:0] DIV_CODE  = DATA_WIDTH'(DIV_EXC_CODE);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic            op_mul_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   count_q;
  logic            req;
  logic            finish;
  logic            exc_now;

  assign fsm_state = state_q;
  // Completion without md_ready can only be the timeout, which is forced to an exception.
  assign exc_now = !md_ready || md_exception;

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    finish       = 1'b0;
    // Gated by reset so stall is low while reset is held, even with a live request.
    req          = (dx_is_mult || dx_is_div) && !flush && reset;
    case (state_q)
      IDLE: begin
        stall = req;
        if (req) state_d = START;
      end
      START: begin
        stall        = 1'b1;
        md_ctrl_mult = op_mul_q && !flush;
        md_ctrl_div  = !op_mul_q && !flush;
        state_d      = flush ? IDLE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (md_ready || (count_q == LAST_BUSY)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_mul_q  <= 1'b0;
      rd_q      <= '0;
      count_q   <= '0;
      md_data_a <= '0;
      md_data_b <= '0;
      wb_valid  <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
    end else begin
      state_q  <= state_d;
      wb_valid <= 1'b0;
      if (state_q == IDLE && req) begin
        md_data_a <= dx_operand_a;
        md_data_b <= dx_operand_b;
        rd_q      <= dx_rd;
        op_mul_q  <= dx_is_mult;
      end
      if (state_q == START) begin
        count_q <= '0;
      end else if (state_q == BUSY && count_q != SAT_VAL) begin
        count_q <= count_q + 1'b1;
      end
      if (finish) begin
        if (exc_now) begin
          wb_valid <= 1'b1;
          wb_reg   <= RS_REG;
          wb_data  <= op_mul_q ? MUL_CODE : DIV_CODE;
        end else begin
          wb_valid <= (rd_q != 5'd0);
          wb_reg   <= rd_q;
          wb_data  <= md_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: a driver task runs one mul/div operation cycle by cycle,
// expected writebacks are queued when driven and popped by a monitor on wb_valid.
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 40;

  logic        clock;
  logic        reset;
  logic        dx_is_mult, dx_is_div;
  logic [31:0] dx_operand_a, dx_operand_b;
  logic [4:0]  dx_rd;
  logic        flush;
  logic [31:0] md_result;
  logic        md_ready, md_exception;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_data_a, md_data_b;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [1:0]  fsm_state;

  logic [36:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  multdiv_sequencer dut (
    .clock(clock), .reset(reset),
    .dx_is_mult(dx_is_mult), .dx_is_div(dx_is_div),
    .dx_operand_a(dx_operand_a), .dx_operand_b(dx_operand_b),
    .dx_rd(dx_rd), .flush(flush),
    .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_data_a(md_data_a), .md_data_b(md_data_b),
    .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_dx();
    dx_is_mult = 1'b0;
    dx_is_div  = 1'b0;
    flush      = 1'b0;
    md_ready   = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", {27'd0, wb_reg, wb_data}, 64'd0);
      end else begin
        check("wb", {27'd0, wb_reg, wb_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  // One operation from its IDLE request cycle. ready_at / flush_at are BUSY cycle
  // indices (-1: never; flush_at -2: flush in START). Returns in DONE or, after a
  // flush, in the following IDLE cycle; DX inputs are left as driven.
  task automatic do_op(input logic mul, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int ready_at, input logic [31:0] res,
                       input logic exc, input int flush_at);
    dx_is_mult = mul; dx_is_div = !mul;
    dx_operand_a = a; dx_operand_b = b; dx_rd = rd; flush = 1'b0;
    #1;
    check("req_state", fsm_state, 0);
    check("req_stall", stall, 1);
    tick();
    flush = (flush_at == -2);
    dx_operand_a = ~a; dx_operand_b = ~b;
    #1;
    check("start_state", fsm_state, 1);
    check("start_stall", stall, 1);
    check("strobe_mul", md_ctrl_mult, mul && flush_at != -2);
    check("strobe_div", md_ctrl_div, !mul && flush_at != -2);
    check("data_a", md_data_a, a);
    check("data_b", md_data_b, b);
    if (flush_at == -2) begin
      tick(); clear_dx(); #1;
      check("flush_idle", fsm_state, 0);
      check("flush_stall", stall, 0);
      return;
    end
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      md_ready = (i == ready_at); md_exception = exc; md_result = res;
      flush = (i == flush_at);
      #1;
      check("busy_state", fsm_state, 2);
      check("busy_stall", stall, 1);
      check("busy_strobe", {md_ctrl_mult, md_ctrl_div}, 0);
      if (flush) begin
        tick(); clear_dx(); #1;
        check("flush_idle", fsm_state, 0);
        check("flush_stall", stall, 0);
        return;
      end
      if (md_ready || i == TIMEOUT - 1) begin
        if (md_ready && !exc) begin
          if (rd != 5'd0) exp_q.push_back({rd, res});
        end else begin
          exp_q.push_back({5'd30, mul ? 32'd4 : 32'd5});
        end
        tick();
        md_ready = 1'b0; md_exception = 1'b0;
        #1;
        check("done_state", fsm_state, 3);
        check("done_stall", stall, 0);
        return;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_dx();
    dx_operand_a = '0; dx_operand_b = '0; dx_rd = '0;
    md_result = '0; md_exception = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    dx_is_mult = 1'b1;
    #1;
    check("rst_stall", stall, 0);
    check("rst_state", fsm_state, 0);
    check("rst_strobe", {md_ctrl_mult, md_ctrl_div}, 0);
    check("rst_wb", {wb_valid, wb_reg, wb_data}, 0);
    check("rst_data", {md_data_a, md_data_b}, 0);
    dx_is_mult = 1'b0;
    reset = 1'b1;
    tick();

    // mult 6*7 -> rd 3, md_ready 32 cycles after the strobe
    do_op(1'b1, 32'd6, 32'd7, 5'd3, 31, 32'd42, 1'b0, -1);
    clear_dx(); tick(); tick();

    // divide by zero -> rstatus
    do_op(1'b0, 32'd9, 32'd0, 5'd8, 5, 32'hdead, 1'b1, -1);
    clear_dx(); tick();

    // mult exception -> code 4
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 5'd9, 0, 32'h0, 1'b1, -1);
    clear_dx(); tick();

    // flush at BUSY 10, late md_ready ignored in IDLE
    do_op(1'b1, 32'd3, 32'd4, 5'd5, 31, 32'd12, 1'b0, 10);
    for (int i = 0; i < 25; i++) begin
      md_ready = (i == 21); md_result = 32'd12;
      #1;
      check("late_state", fsm_state, 0);
      check("late_stall", stall, 0);
      tick();
    end
    md_ready = 1'b0;

    // flush in START: no strobe
    do_op(1'b0, 32'd100, 32'd7, 5'd6, 0, 32'd14, 1'b0, -2);
    tick();

    // flush and md_ready together: flush wins
    do_op(1'b0, 32'd100, 32'd7, 5'd6, 3, 32'd14, 1'b0, 3);
    tick();

    // timeout on div
    do_op(1'b0, 32'd50, 32'd5, 5'd7, -1, 32'd10, 1'b0, -1);
    clear_dx(); tick();

    // rd == 0 never written
    do_op(1'b1, 32'd2, 32'd2, 5'd0, 2, 32'd4, 1'b0, -1);
    clear_dx(); tick();

    // reset in BUSY
    dx_is_mult = 1'b1; dx_operand_a = 32'd11; dx_operand_b = 32'd12; dx_rd = 5'd4;
    tick(); tick(); tick(); tick();
    #2;
    check("pre_rst_state", fsm_state, 2);
    reset = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_strobe", {md_ctrl_mult, md_ctrl_div}, 0);
    check("mid_rst_wb", wb_valid, 0);
    check("mid_rst_state", fsm_state, 0);
    check("mid_rst_data", md_data_a, 0);
    tick();
    reset = 1'b1; clear_dx();
    md_ready = 1'b1; md_result = 32'd132;
    #1;
    check("post_rst_state", fsm_state, 0);
    tick(); md_ready = 1'b0; #1;
    check("post_rst_idle", fsm_state, 0);
    tick();

    // div held through DONE, then a new mul: strobe two cycles after DONE
    do_op(1'b0, 32'd21, 32'd3, 5'd12, 4, 32'd7, 1'b0, -1);
    tick();
    check("no_retrigger", fsm_state, 0);
    do_op(1'b1, 32'd5, 32'd5, 5'd13, 1, 32'd25, 1'b0, -1);
    clear_dx(); tick();

    // random operations
    for (int n = 0; n < 6; n++) begin
      do_op(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 35), $urandom, ($urandom_range(0, 3) == 0), -1);
      clear_dx(); tick();
    end

    tick(); tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
